// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake bundle for alu_op_sequencer.
// master = requester side, slave = sequencer side.
interface alu_op_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       in_funct;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [WIDTH-1:0] out_hi;
    logic             out_zero;
    logic             out_ovf;
    logic             out_err;

    modport master (
        output in_valid, in_funct, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_hi, out_zero, out_ovf, out_err
    );

    modport slave (
        input  in_valid, in_funct, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_hi, out_zero, out_ovf, out_err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences R-type operations onto an external 32-bit ripple ALU, including the
// two-pass slt and the 32-iteration shift-add multu.
module alu_op_sequencer #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MUL_ITERS = 32
) (
    input  logic             clk,
    input  logic             rst,
    alu_op_sequencer_if.slave bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    output logic             alu_binv,
    output logic             alu_sel1,
    output logic             alu_sel0,
    output logic [WIDTH-1:0] alu_less,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_co
);

    localparam int unsigned CntW = $clog2(MUL_ITERS + 1);

    localparam logic [5:0] FnAdd   = 6'h20;
    localparam logic [5:0] FnAddu  = 6'h21;
    localparam logic [5:0] FnSub   = 6'h22;
    localparam logic [5:0] FnSubu  = 6'h23;
    localparam logic [5:0] FnAnd   = 6'h24;
    localparam logic [5:0] FnOr    = 6'h25;
    localparam logic [5:0] FnSlt   = 6'h2A;
    localparam logic [5:0] FnMultu = 6'h19;

    typedef enum logic [2:0] {StIdle, StExec, StSlt2, StMul, StDone} state_e;

    state_e            state;
    logic [5:0]        funct_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  hi_acc;
    logic [WIDTH-1:0]  lo_acc;
    logic [CntW-1:0]   count;
    logic              set_q;

    logic [WIDTH-1:0]  b_eff;
    logic              ovf_raw;
    logic              signed_arith;
    logic [WIDTH-1:0]  hi_next;
    logic [WIDTH-1:0]  lo_next;

    assign bus.in_ready = (state == StIdle);

    // ALU pins depend only on registered state, never on the request inputs.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_cin  = 1'b0;
        alu_binv = 1'b0;
        alu_sel1 = 1'b0;
        alu_sel0 = 1'b0;
        alu_less = '0;
        unique case (state)
            StExec: begin
                alu_a = a_q;
                alu_b = b_q;
                case (funct_q)
                    FnAdd, FnAddu: alu_sel1 = 1'b1;
                    FnSub, FnSubu, FnSlt: begin
                        alu_sel1 = 1'b1;
                        alu_binv = 1'b1;
                        alu_cin  = 1'b1;
                    end
                    FnOr:    alu_sel0 = 1'b1;
                    default: ;
                endcase
            end
            StSlt2: begin
                alu_sel1 = 1'b1;
                alu_sel0 = 1'b1;
                alu_less = {{(WIDTH-1){1'b0}}, set_q};
            end
            StMul: begin
                alu_a    = hi_acc;
                alu_b    = b_q;
                alu_sel1 = 1'b1;
            end
            default: ;
        endcase
    end

    assign b_eff        = alu_binv ? ~alu_b : alu_b;
    assign ovf_raw      = (a_q[WIDTH-1] == b_eff[WIDTH-1]) &&
                          (alu_result[WIDTH-1] != a_q[WIDTH-1]);
    assign signed_arith = (funct_q == FnAdd) || (funct_q == FnSub);

    // One shift-add step: add multiplicand into the high half when lo bit 0 is set.
    always_comb begin
        if (lo_acc[0]) begin
            hi_next = {alu_co, alu_result[WIDTH-1:1]};
            lo_next = {alu_result[0], lo_acc[WIDTH-1:1]};
        end else begin
            hi_next = {1'b0, hi_acc[WIDTH-1:1]};
            lo_next = {hi_acc[0], lo_acc[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= StIdle;
            funct_q        <= '0;
            a_q            <= '0;
            b_q            <= '0;
            hi_acc         <= '0;
            lo_acc         <= '0;
            count          <= '0;
            set_q          <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_result <= '0;
            bus.out_hi     <= '0;
            bus.out_zero   <= 1'b0;
            bus.out_ovf    <= 1'b0;
            bus.out_err    <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.in_valid) begin
                        funct_q <= bus.in_funct;
                        a_q     <= bus.in_a;
                        b_q     <= bus.in_b;
                        hi_acc  <= '0;
                        lo_acc  <= bus.in_a;
                        count   <= '0;
                        case (bus.in_funct)
                            FnMultu: state <= StMul;
                            FnAdd, FnAddu, FnSub, FnSubu, FnAnd, FnOr, FnSlt: state <= StExec;
                            default: begin
                                state          <= StDone;
                                bus.out_valid  <= 1'b1;
                                bus.out_result <= '0;
                                bus.out_hi     <= '0;
                                bus.out_zero   <= 1'b1;
                                bus.out_ovf    <= 1'b0;
                                bus.out_err    <= 1'b1;
                            end
                        endcase
                    end
                end
                StExec: begin
                    if (funct_q == FnSlt) begin
                        set_q <= alu_result[WIDTH-1] ^ ovf_raw;
                        state <= StSlt2;
                    end else begin
                        state          <= StDone;
                        bus.out_valid  <= 1'b1;
                        bus.out_result <= alu_result;
                        bus.out_hi     <= '0;
                        bus.out_zero   <= (alu_result == '0);
                        bus.out_ovf    <= signed_arith & ovf_raw;
                        bus.out_err    <= 1'b0;
                    end
                end
                StSlt2: begin
                    state          <= StDone;
                    bus.out_valid  <= 1'b1;
                    bus.out_result <= alu_result;
                    bus.out_hi     <= '0;
                    bus.out_zero   <= (alu_result == '0);
                    bus.out_ovf    <= 1'b0;
                    bus.out_err    <= 1'b0;
                end
                StMul: begin
                    hi_acc <= hi_next;
                    lo_acc <= lo_next;
                    count  <= count + 1'b1;
                    if (count == CntW'(MUL_ITERS - 1)) begin
                        state          <= StDone;
                        bus.out_valid  <= 1'b1;
                        bus.out_result <= lo_next;
                        bus.out_hi     <= hi_next;
                        bus.out_zero   <= (lo_next == '0);
                        bus.out_ovf    <= 1'b0;
                        bus.out_err    <= 1'b0;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench: arithmetic reference model plus a behavioural ALU.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] alu_a, alu_b, alu_less, alu_result;
    logic        alu_cin, alu_binv, alu_sel1, alu_sel0, alu_co;
    logic [32:0] alu_sum;

    int checks = 0;
    int errors = 0;

    alu_op_sequencer_if #(.WIDTH(32)) bus ();

    alu_op_sequencer #(.WIDTH(32), .MUL_ITERS(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cin    (alu_cin),
        .alu_binv   (alu_binv),
        .alu_sel1   (alu_sel1),
        .alu_sel0   (alu_sel0),
        .alu_less   (alu_less),
        .alu_result (alu_result),
        .alu_co     (alu_co)
    );

    always #5 clk = ~clk;

    // Behavioural ripple ALU.
    always_comb begin
        alu_sum = {1'b0, alu_a} + {1'b0, (alu_binv ? ~alu_b : alu_b)} + {32'b0, alu_cin};
        alu_co  = 1'b0;
        case ({alu_sel1, alu_sel0})
            2'b00: alu_result = alu_a & (alu_binv ? ~alu_b : alu_b);
            2'b01: alu_result = alu_a | (alu_binv ? ~alu_b : alu_b);
            2'b10: begin
                alu_result = alu_sum[31:0];
                alu_co     = alu_sum[32];
            end
            default: alu_result = alu_less;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Reference: MIPS semantics from plain arithmetic; lat = edges after accept to out_valid.
    task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic [31:0] hi, output logic ovf,
                         output logic err, output int lat);
        longint s;
        logic [63:0] p;
        res = '0; hi = '0; ovf = 1'b0; err = 1'b0; lat = 1;
        case (f)
            6'h20, 6'h21: begin
                res = a + b;
                s = longint'($signed(a)) + longint'($signed(b));
                ovf = (f == 6'h20) && (s > 64'sd2147483647 || s < -64'sd2147483648);
            end
            6'h22, 6'h23: begin
                res = a - b;
                s = longint'($signed(a)) - longint'($signed(b));
                ovf = (f == 6'h22) && (s > 64'sd2147483647 || s < -64'sd2147483648);
            end
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h2A: begin
                res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                lat = 2;
            end
            6'h19: begin
                p = {32'b0, a} * {32'b0, b};
                res = p[31:0];
                hi = p[63:32];
                lat = 32;
            end
            default: begin
                err = 1'b1;
                lat = 0;
            end
        endcase
    endtask

    task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
        logic [31:0] er, eh;
        logic eo, ee;
        int el, lat;
        model(f, a, b, er, eh, eo, ee, el);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_funct = f;
        bus.in_a     = a;
        bus.in_b     = b;
        check("in_ready_idle", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(el));
        check("result", 64'(bus.out_result), 64'(er));
        check("hi", 64'(bus.out_hi), 64'(eh));
        check("zero", 64'(bus.out_zero), 64'(er == 32'd0));
        check("ovf", 64'(bus.out_ovf), 64'(eo));
        check("err", 64'(bus.out_err), 64'(ee));
        // Competing request while the response is back-pressured must be ignored.
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_funct = 6'h20;
            bus.in_a     = $urandom;
            bus.in_b     = $urandom;
            check("busy_in_ready", 64'(bus.in_ready), 64'd0);
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_result", 64'(bus.out_result), 64'(er));
            check("hold_hi", 64'(bus.out_hi), 64'(eh));
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("valid_drop", 64'(bus.out_valid), 64'd0);
        check("ready_after_hs", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [5:0] fn_tab [9];
        fn_tab = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h19, 6'h3F};
        bus.in_valid  = 1'b0;
        bus.in_funct  = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_result", 64'(bus.out_result), 64'd0);
        check("rst_alu_a", 64'(alu_a), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        do_op(6'h20, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        do_op(6'h21, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        do_op(6'h22, 32'd5, 32'd5, 0);
        do_op(6'h24, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0);
        do_op(6'h25, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0);
        do_op(6'h2A, 32'hFFFF_FFFF, 32'd1, 0);
        do_op(6'h2A, 32'h7FFF_FFFF, 32'h8000_0000, 0);
        do_op(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(6'h19, 32'd7, 32'd6, 5);

        for (int n = 0; n < 40; n++) begin
            logic [5:0] f;
            f = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 8)];
            do_op(f, pick_operand(), pick_operand(), $urandom_range(0, 3));
        end

        // Reset in the middle of a multu.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_funct = 6'h19;
        bus.in_a     = 32'h1234_5678;
        bus.in_b     = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_mul_busy", 64'(bus.in_ready), 64'd0);
        rst = 1'b1;
        #1;
        check("mrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mrst_alu_ab", {alu_a, alu_b}, 64'd0);
        check("mrst_alu_ctl", 64'({alu_cin, alu_binv, alu_sel1, alu_sel0}), 64'd0);
        check("mrst_alu_less", 64'(alu_less), 64'd0);
        check("mrst_result", 64'({bus.out_result, bus.out_hi}), 64'd0);
        check("mrst_flags", 64'({bus.out_zero, bus.out_ovf, bus.out_err}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        check("mrst_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (40) @(posedge clk);
        #1;
        check("no_stale_resp", 64'(bus.out_valid), 64'd0);

        do_op(6'h20, 32'd2, 32'd3, 0);
        do_op(6'h3F, 32'hDEAD_BEEF, 32'h1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
